// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the PC register
// Optional feature macro: PC_SEQ_PERF_EN (adds instr_retired / stall_cycles counters)
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] current_pc,
  input  logic            mem_ready,
  input  logic            is_jump,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic            is_halt,
  input  logic [PC_W-1:0] target,
  output logic            fetch_req,
  output logic            ir_load,
  output logic            reg_write,
  output logic            pc_change,
  output logic [PC_W-1:0] next_pc,
  output logic [2:0]      state,
  output logic            halted
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     instr_retired,
  output logic [15:0]     stall_cycles
`endif
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            fetch_req_q, fetch_req_d;
  logic            ir_load_q, ir_load_d;
  logic            reg_write_q, reg_write_d;
  logic            pc_change_q, pc_change_d;
  logic            halted_q, halted_d;
  logic            wb_en_q, wb_en_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic [PC_W-1:0] seq_pc;

  assign seq_pc = current_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // Next state plus the registered strobes that belong to that next state
  always_comb begin
    state_d     = state_q;
    fetch_req_d = 1'b0;
    ir_load_d   = 1'b0;
    reg_write_d = 1'b0;
    pc_change_d = 1'b0;
    halted_d    = 1'b0;
    wb_en_d     = wb_en_q;
    next_pc_d   = next_pc_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d   = ST_DECODE;
          ir_load_d = 1'b1;
        end else begin
          fetch_req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt) begin
          // PC is left pointing at the HALT instruction itself
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          if (is_jump || (is_branch && branch_taken)) begin
            next_pc_d = target;
          end else begin
            next_pc_d = seq_pc;
          end
          wb_en_d     = !is_jump && !is_branch;
          state_d     = ST_WB;
          pc_change_d = 1'b1;
          reg_write_d = !is_jump && !is_branch;
        end
      end
      ST_WB: begin
        state_d     = ST_FETCH;
        fetch_req_d = 1'b1;
      end
      ST_HALT: begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
      default: begin
        // Illegal encodings recover into FETCH with every strobe low
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      fetch_req_q <= 1'b0;
      ir_load_q   <= 1'b0;
      reg_write_q <= 1'b0;
      pc_change_q <= 1'b0;
      halted_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      next_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_req_q <= fetch_req_d;
      ir_load_q   <= ir_load_d;
      reg_write_q <= reg_write_d;
      pc_change_q <= pc_change_d;
      halted_q    <= halted_d;
      wb_en_q     <= wb_en_d;
      next_pc_q   <= next_pc_d;
    end
  end

  assign fetch_req = fetch_req_q;
  assign ir_load   = ir_load_q;
  assign reg_write = reg_write_q;
  assign pc_change = pc_change_q;
  assign next_pc   = next_pc_q;
  assign state     = state_q;
  assign halted    = halted_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] instr_retired_q, instr_retired_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Saturating counts of retired instructions and memory stall cycles
  always_comb begin
    instr_retired_d = instr_retired_q;
    stall_cycles_d  = stall_cycles_q;
    if ((state_q == ST_WB) && (instr_retired_q != '1)) begin
      instr_retired_d = instr_retired_q + 32'd1;
    end
    if ((state_q == ST_FETCH) && !mem_ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Counter registers cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_retired_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      instr_retired_q <= instr_retired_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign instr_retired = instr_retired_q;
  assign stall_cycles  = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] current_pc;
  logic        mem_ready;
  logic        is_jump;
  logic        is_branch;
  logic        branch_taken;
  logic        is_halt;
  logic [15:0] target;
  logic        fetch_req;
  logic        ir_load;
  logic        reg_write;
  logic        pc_change;
  logic [15:0] next_pc;
  logic [2:0]  state;
  logic        halted;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] instr_retired;
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .current_pc   (current_pc),
    .mem_ready    (mem_ready),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .is_halt      (is_halt),
    .target       (target),
    .fetch_req    (fetch_req),
    .ir_load      (ir_load),
    .reg_write    (reg_write),
    .pc_change    (pc_change),
    .next_pc      (next_pc),
    .state        (state),
    .halted       (halted)
`ifdef PC_SEQ_PERF_EN
    ,
    .instr_retired(instr_retired),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic j, input logic b, input logic bt, input logic h,
                         input logic [15:0] tgt, input logic [15:0] pc);
    is_jump      = j;
    is_branch    = b;
    branch_taken = bt;
    is_halt      = h;
    target       = tgt;
    current_pc   = pc;
  endtask

  // From FETCH with mem_ready=1: step to WB and check the PC update
  task automatic run_to_wb(input string tag, input logic [15:0] exp_pc, input logic exp_rw);
    tick();
    chk({tag, "_decode_state"}, 32'(state), 32'd1);
    tick();
    chk({tag, "_exec_state"}, 32'(state), 32'd2);
    tick();
    chk({tag, "_wb_state"}, 32'(state), 32'd3);
    chk({tag, "_wb_pc_change"}, 32'(pc_change), 32'd1);
    chk({tag, "_wb_next_pc"}, 32'(next_pc), 32'(exp_pc));
    chk({tag, "_wb_reg_write"}, 32'(reg_write), 32'(exp_rw));
    tick();
    chk({tag, "_back_fetch"}, 32'(state), 32'd0);
    chk({tag, "_fetch_pc_change"}, 32'(pc_change), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005);

    // Test 1: reset and the basic sequential instruction
    tick();
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_next_pc", 32'(next_pc), 32'h0000);
    chk("rst_halted", 32'(halted), 32'd0);
    tick();
    chk("t1_decode", 32'(state), 32'd1);
    chk("t1_ir_load", 32'(ir_load), 32'd1);
    tick();
    chk("t1_exec", 32'(state), 32'd2);
    chk("t1_ir_load_off", 32'(ir_load), 32'd0);
    tick();
    chk("t1_wb", 32'(state), 32'd3);
    chk("t1_pc_change", 32'(pc_change), 32'd1);
    chk("t1_next_pc", 32'(next_pc), 32'h0006);
    chk("t1_reg_write", 32'(reg_write), 32'd1);
    tick();
    chk("t1_fetch", 32'(state), 32'd0);
    chk("t1_fetch_req", 32'(fetch_req), 32'd1);
    chk("t1_next_pc_hold", 32'(next_pc), 32'h0006);
    tick();
    tick();
    tick();
    chk("t1_second_wb", 32'(state), 32'd3);
    chk("t1_second_pc_change", 32'(pc_change), 32'd1);
    tick();

    // Test 2: sequential wrap at the top of the address space
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF);
    run_to_wb("t2_wrap", 16'h0000, 1'b1);

    // Test 3: jump, branch not taken, branch taken
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0007);
    run_to_wb("t3_jump", 16'h0100, 1'b0);
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0010);
    run_to_wb("t3_br_nt", 16'h0011, 1'b0);
    set_dec(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0010);
    run_to_wb("t3_br_t", 16'h0020, 1'b0);

    // Test 4: three stalled FETCH cycles after a fresh reset
    reset     = 1'b1;
    mem_ready = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030);
    tick();
    reset = 1'b0;
    chk("t4_first_fetch_req", 32'(fetch_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_state", 32'(state), 32'd0);
      chk("t4_stall_fetch_req", 32'(fetch_req), 32'd1);
      chk("t4_stall_ir_load", 32'(ir_load), 32'd0);
    end
    mem_ready = 1'b1;
    tick();
    chk("t4_decode", 32'(state), 32'd1);
    chk("t4_ir_load", 32'(ir_load), 32'd1);
`ifdef PC_SEQ_PERF_EN
    chk("t4_stall_cycles", 32'(stall_cycles), 32'd3);
`endif
    tick();
    chk("t4_ir_load_once", 32'(ir_load), 32'd0);
    tick();
    chk("t4_wb_next_pc", 32'(next_pc), 32'h0031);
    tick();
`ifdef PC_SEQ_PERF_EN
    chk("t4_instr_retired", instr_retired, 32'd1);
`endif

    // Test 5: HALT outranks jump and parks until reset
    set_dec(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0031);
    tick();
    tick();
    tick();
    chk("t5_halt_state", 32'(state), 32'd4);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_next_pc_held", 32'(next_pc), 32'h0031);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick();
      chk("t5_park_state", 32'(state), 32'd4);
      chk("t5_park_halted", 32'(halted), 32'd1);
      chk("t5_park_pc_change", 32'(pc_change), 32'd0);
      chk("t5_park_fetch_req", 32'(fetch_req), 32'd0);
      chk("t5_park_reg_write", 32'(reg_write), 32'd0);
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_state", 32'(state), 32'd0);
    chk("t5_rst_halted", 32'(halted), 32'd0);
    chk("t5_rst_next_pc", 32'(next_pc), 32'h0000);

    // Test 6: reset aborts an instruction in EXEC and in WB
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0040);
    tick();
    tick();
    chk("t6_in_exec", 32'(state), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_exec_rst_state", 32'(state), 32'd0);
    chk("t6_exec_rst_pc_change", 32'(pc_change), 32'd0);
    chk("t6_exec_rst_reg_write", 32'(reg_write), 32'd0);
    chk("t6_exec_rst_next_pc", 32'(next_pc), 32'h0000);
    tick();
    tick();
    tick();
    chk("t6_in_wb", 32'(state), 32'd3);
    chk("t6_wb_next_pc", 32'(next_pc), 32'h0041);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    mem_ready = 1'b0;
    chk("t6_wb_rst_state", 32'(state), 32'd0);
    chk("t6_wb_rst_pc_change", 32'(pc_change), 32'd0);
    chk("t6_wb_rst_reg_write", 32'(reg_write), 32'd0);
    chk("t6_wb_rst_next_pc", 32'(next_pc), 32'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_update", 32'(pc_change), 32'd0);
      chk("t6_no_update_pc", 32'(next_pc), 32'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle instruction sequencer that drives the program-counter register's change strobe and next-PC value. It steps each instruction through FETCH, DECODE, EXEC and WB, stalls on instruction-memory readiness, and selects the next PC from sequential, jump or branch sources. A HALT instruction parks the machine until reset. It sits between the instruction memory/decoder and the PC register.

Parameters:
PC_W, 16, width of the PC and of the target/next_pc buses
RESET_PC, 0, value driven on next_pc after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
current_pc  in  PC_W  current PC from the PC register
mem_ready  in  1  instruction memory data valid (sampled in FETCH only)
is_jump  in  1  decoded unconditional jump
is_branch  in  1  decoded conditional branch
branch_taken  in  1  branch condition result
is_halt  in  1  decoded HALT
target  in  PC_W  jump/branch target address
fetch_req  out  1  instruction fetch request
ir_load  out  1  one-cycle instruction-register load strobe
reg_write  out  1  register-file write enable
pc_change  out  1  PC update strobe to the PC register
next_pc  out  PC_W  next PC value to the PC register
state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4
halted  out  1  machine halted

Behaviour:
- One clock (clk). Reset is synchronous and active-high: on any clk edge with reset=1, state=FETCH, fetch_req=0, ir_load=0, reg_write=0, pc_change=0, halted=0, next_pc=RESET_PC. Reset applies from any state, including mid-instruction and HALT.
- All outputs are registered and update on the same edge as state.
- FETCH:
  - fetch_req=1 every cycle spent in FETCH, except the first cycle after reset release, where it is 0 because it is registered.
  - While mem_ready=0, stay in FETCH and keep ir_load=0.
  - When mem_ready=1, pulse ir_load for exactly one cycle (the DECODE cycle) and go to DECODE.
- DECODE: one cycle for the decoder to settle, then go to EXEC unconditionally. Decoder inputs are ignored here.
- EXEC: decoder inputs are sampled once, with priority is_halt > is_jump > is_branch > sequential.
  - is_halt: go to HALT. next_pc is held and pc_change stays 0, so the PC keeps pointing at the HALT instruction.
  - is_jump: next_pc=target.
  - is_branch with branch_taken=1: next_pc=target.
  - is_branch with branch_taken=0, or plain sequential: next_pc=current_pc+1, modulo 2^PC_W (0xFFFF wraps to 0x0000).
  - Latch wb_en = !is_jump && !is_branch, then go to WB.
- WB: pc_change=1 and reg_write=wb_en for exactly this one cycle, then go to FETCH. next_pc holds its value until the next EXEC.
- HALT: halted=1; pc_change, fetch_req and reg_write stay 0. Only reset leaves HALT.
- mem_ready outside FETCH is ignored.
- Minimum instruction time is 4 cycles with mem_ready=1; each cycle mem_ready is low adds one cycle.
- Illegal state encodings (5-7) go to FETCH on the next edge with all strobes 0.

Optional Feature:
PC_SEQ_PERF_EN:
- Defined: adds output instr_retired[31:0], which increments on each WB cycle, and output stall_cycles[15:0], which increments on each FETCH cycle with mem_ready=0. Both counters saturate at all-ones and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset, mem_ready=1, decoder inputs 0, current_pc=0x0005 -> state sequence 0,1,2,3,0; in the WB cycle pc_change=1, next_pc=0x0006, reg_write=1; next WB four cycles later.
2. Sequential instruction at current_pc=0xFFFF -> WB cycle shows next_pc=0x0000, pc_change=1.
3. is_jump=1, target=0x0100 -> next_pc=0x0100, reg_write=0. Then is_branch=1, branch_taken=0 at current_pc=0x0010 -> next_pc=0x0011, reg_write=0. Then branch_taken=1, target=0x0020 -> next_pc=0x0020.
4. mem_ready low for 3 FETCH cycles, then high -> fetch_req=1 throughout, ir_load pulses once in the following DECODE cycle; with PC_SEQ_PERF_EN defined, stall_cycles=3 and instr_retired=1 after WB.
5. is_halt=1 and is_jump=1 together in EXEC -> state=4, halted=1, pc_change=0 for 20 following cycles; then reset=1 for one edge -> state=0, halted=0, next_pc=0.
6. reset asserted for one edge while in EXEC and again while in WB -> next cycle state=0, pc_change=0, reg_write=0, next_pc=RESET_PC; no PC update is issued for the aborted instruction.
